my_interrupt_unit: RTL and testbench
====================================

# my_interrupt_unit

Parametrised, multi-source interrupt unit for the Basic Computer datapath. It generalises the controller's single-flag interrupt logic (R, IEN, FGI) to N_SRC maskable, fixed-priority sources, each with its own save/entry vector. It sits beside the controller: it raises `r_flag` to steal the next fetch, supplies the vector addresses the controller drives onto AR and PC during R·T0..T2, and acknowledges the granted source.

## Interface
- N_SRC, 4: number of interrupt sources (1..16); index 0 is highest priority.
- AW, 12: address width of vector outputs.
- VEC_BASE, 12'h000: base address of the vector table.
- MASK_RST, all ones: reset value of the mask register.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flag  in  N_SRC  level requests from devices (FGI, FGO, ...).
- fetch_idle  in  1  high while controller T0, T1 and T2 are all inactive.
- t2  in  1  controller T2 decode.
- ion  in  1  one-cycle pulse from the ION instruction.
- iof  in  1  one-cycle pulse from the IOF instruction.
- msk_we  in  1  mask write strobe.
- msk_data  in  N_SRC  new mask value.
- eoi  in  1  end-of-interrupt pulse; used only with nesting.
- r_flag  out  1  interrupt-cycle flag (R).
- ien  out  1  global interrupt enable.
- vec_save  out  AW  PC save address for the granted source.
- vec_entry  out  AW  ISR entry address for the granted source.
- ack  out  N_SRC  one-hot, one-cycle grant acknowledge.
- pend  out  N_SRC  combinational `flag & mask`, used by skip instructions.
- in_svc  out  N_SRC  in-service bits.

## Operation
- Registers: `ien`, `r_flag`, `mask`, `grant` (index, log2 N_SRC bits), `ack`, `in_svc`.
- eligible = `flag & mask & prio_ok`; `prio_ok` is all ones without nesting.
- Arm: at a clock edge with `fetch_idle & ien & ~r_flag & |eligible`:
  - `r_flag` is set to 1.
  - `grant` latches the lowest set index of `eligible`.
- While `r_flag` = 1, the following are frozen:
  - `grant`, `vec_save` = VEC_BASE + 2·grant, and `vec_entry` = VEC_BASE + 2·grant + 1.
  - Both vectors are computed modulo 2^AW and are registered.
- Controller use: R·T0 puts `vec_save` into AR; R·T1 writes PC to memory; R·T2 loads `vec_entry` into PC.
- Exit: at the edge with `r_flag & t2`:
  - `r_flag` and `ien` are cleared.
  - `ack` is set to onehot(grant) for exactly the next cycle, then returns to 0.
- ion/iof handling:
  - `ion` sets `ien`; `iof` clears it.
  - If `ion` and `iof` arrive together, iof wins.
  - Exit clearing `ien` overrides a simultaneous `ion`.
- `msk_we` loads `mask` at the edge.
  - A mask write never cancels an armed cycle.
  - If a flag drops while armed, the cycle still completes with the latched vector.
- Reset values: `r_flag` = 0, `ien` = 0, `grant` = 0, `ack` = 0, `in_svc` = 0, `mask` = MASK_RST. The vectors read VEC_BASE and VEC_BASE+1.
- Reset mid-cycle aborts the cycle, and no `ack` is issued.

## Timing
- Arm latency: `r_flag` rises one edge after the qualifying cycle. The controller begins R·T0 at the following fetch.
- `vec_*` outputs are valid from the cycle `r_flag` rises through R·T2.
- `ack` occurs 1 cycle after R·T2, with width exactly 1.
- `pend` has zero latency (combinational).
- No arm while `r_flag` = 1 or during T0–T2.

## Configuration
- `INT_NEST_EN` defined:
  - At exit, `in_svc[grant]` is set.
  - `prio_ok[k]` = 1 only when k < index of the lowest set `in_svc` bit, or when `in_svc` = 0.
  - `eoi` clears the lowest set `in_svc` bit at the edge. If `eoi` and exit coincide, clear first, then set.
  - Effect: once the ISR re-enables interrupts, only higher-priority sources preempt.
- Undefined: `in_svc` is held at 0, `eoi` is ignored, and any masked pending source may interrupt.

## Test plan
- Reset, `ion`, then flag=4'b0100 with fetch_idle=1:
  - `r_flag` rises next edge; vec_save=0x004, vec_entry=0x005.
  - Pulse t2 → `ien`=0, then ack=4'b0100 for 1 cycle.
- flag=4'b1010 with ien=1 → grant=1, vec_save=0x002. Source 3 does not arm until ION is re-executed and flag[1] is cleared.
- mask=4'b1101 with flag=4'b0010 → no arm and pend=0. Writing mask=4'b1111 → arm on the next fetch_idle.
- ion and iof in the same cycle → ien=0. ion coincident with R·t2 → ien=0.
- Assert reset while armed before t2 → r_flag=0 and ack stays 0.
- With `INT_NEST_EN`:
  - In ISR for source 2 with ion pulsed, flag[3] is ignored while flag[0] arms.
  - eoi clears in_svc[0] and leaves in_svc[2] set.

Source files
------------

// File: rtl/my_interrupt_unit.sv
// ---------------------------------------------------------------------------
// my_interrupt_unit
//
// Multi-source, fixed-priority interrupt unit for the Basic Computer
// datapath. It extends the single R/IEN/FGI interrupt scheme to N_SRC
// maskable sources. Each source has its own save/entry vector pair. Index 0
// has the highest priority.
//
// Optional feature macro: INT_NEST_EN
//   When defined, in-service tracking enables priority nesting. Once the ISR
//   re-enables interrupts, only sources of higher priority than the lowest
//   in-service index can preempt it. eoi retires the lowest in-service bit.
//   When undefined, in_svc reads 0 and eoi is ignored.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   flag       in   level interrupt requests, one per source
//   fetch_idle in   controller T0/T1/T2 all inactive
//   t2         in   controller T2 decode
//   ion, iof   in   ION / IOF instruction pulses
//   msk_we     in   mask write strobe
//   msk_data   in   new mask value
//   eoi        in   end-of-interrupt pulse (nesting only)
//   r_flag     out  interrupt-cycle flag R
//   ien        out  global interrupt enable
//   vec_save   out  PC save address of the granted source
//   vec_entry  out  ISR entry address of the granted source
//   ack        out  one-hot, one-cycle grant acknowledge
//   pend       out  flag & mask (combinational)
//   in_svc     out  in-service bits
// ---------------------------------------------------------------------------
module my_interrupt_unit #(
    parameter int                N_SRC    = 4,
    parameter int                AW       = 12,
    parameter logic [AW-1:0]     VEC_BASE = '0,
    parameter logic [N_SRC-1:0]  MASK_RST = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] flag,
    input  logic             fetch_idle,
    input  logic             t2,
    input  logic             ion,
    input  logic             iof,
    input  logic             msk_we,
    input  logic [N_SRC-1:0] msk_data,
    input  logic             eoi,
    output logic             r_flag,
    output logic             ien,
    output logic [AW-1:0]    vec_save,
    output logic [AW-1:0]    vec_entry,
    output logic [N_SRC-1:0] ack,
    output logic [N_SRC-1:0] pend,
    output logic [N_SRC-1:0] in_svc
);

    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    // Index of the lowest set bit. This is the highest-priority source.
    function automatic logic [GW-1:0] f_lowest(input logic [N_SRC-1:0] v);
        logic [GW-1:0] idx;
        idx = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (v[k]) idx = GW'(k);
        end
        return idx;
    endfunction

    logic             r_rflag;
    logic             r_ien;
    logic [N_SRC-1:0] r_mask;
    logic [GW-1:0]    r_grant;
    logic [N_SRC-1:0] r_ack;
    logic [AW-1:0]    r_vec_save;
    logic [AW-1:0]    r_vec_entry;
    logic [N_SRC-1:0] r_in_svc;

    logic [N_SRC-1:0] w_prio_ok;
    logic [N_SRC-1:0] w_eligible;
    logic [GW-1:0]    w_idx;
    logic [AW-1:0]    w_vsave;
    logic [AW-1:0]    w_ventry;
    logic [N_SRC-1:0] w_onehot;
    logic             w_arm;
    logic             w_exit;

    assign pend       = flag & r_mask;
    assign w_eligible = pend & w_prio_ok;
    assign w_idx      = f_lowest(w_eligible);

    // The vectors wrap modulo 2^AW because the sum is kept at AW bits.
    assign w_vsave    = VEC_BASE + (AW'(w_idx) << 1);
    assign w_ventry   = w_vsave + AW'(1);
    assign w_onehot   = N_SRC'(1) << r_grant;

    assign w_arm  = fetch_idle & r_ien & ~r_rflag & (|w_eligible);
    assign w_exit = r_rflag & t2;

    // w_arm needs R low and w_exit needs R high, so the two never coincide.
    // The vectors are loaded only on arm, so they stay frozen while R is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rflag     <= 1'b0;
            r_ien       <= 1'b0;
            r_mask      <= MASK_RST;
            r_grant     <= '0;
            r_ack       <= '0;
            r_vec_save  <= VEC_BASE;
            r_vec_entry <= VEC_BASE + AW'(1);
        end else begin
            if (w_arm) begin
                r_rflag     <= 1'b1;
                r_grant     <= w_idx;
                r_vec_save  <= w_vsave;
                r_vec_entry <= w_ventry;
            end else if (w_exit) begin
                r_rflag <= 1'b0;
            end

            // Exit and IOF both dominate a coincident ION.
            if (w_exit || iof) begin
                r_ien <= 1'b0;
            end else if (ion) begin
                r_ien <= 1'b1;
            end

            r_ack <= w_exit ? w_onehot : '0;

            // A mask write only affects future arming. An armed cycle completes.
            if (msk_we) begin
                r_mask <= msk_data;
            end
        end
    end

`ifdef INT_NEST_EN
    logic [GW-1:0]    w_svc_low;
    logic [N_SRC-1:0] w_svc_after_eoi;

    assign w_svc_low = f_lowest(r_in_svc);

    // Only sources strictly above the active priority level may preempt.
    always_comb begin
        w_prio_ok = '1;
        if (r_in_svc != '0) begin
            for (int k = 0; k < N_SRC; k++) begin
                w_prio_ok[k] = (k < int'(w_svc_low));
            end
        end
    end

    // v & (~v + 1) isolates the lowest set bit. eoi clears it before exit sets.
    assign w_svc_after_eoi = eoi ? (r_in_svc & ~(r_in_svc & (~r_in_svc + N_SRC'(1))))
                                 : r_in_svc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_svc <= '0;
        end else begin
            r_in_svc <= w_svc_after_eoi | (w_exit ? w_onehot : '0);
        end
    end
`else
    logic w_unused_eoi;

    assign w_prio_ok    = '1;
    assign r_in_svc     = '0;
    assign w_unused_eoi = eoi;
`endif

    assign r_flag    = r_rflag;
    assign ien       = r_ien;
    assign vec_save  = r_vec_save;
    assign vec_entry = r_vec_entry;
    assign ack       = r_ack;
    assign in_svc    = r_in_svc;

endmodule

// File: tb/tb_my_interrupt_unit.sv
module tb_my_interrupt_unit;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] flag = '0;
    logic         fetch_idle = 1'b0;
    logic         t2 = 1'b0;
    logic         ion = 1'b0;
    logic         iof = 1'b0;
    logic         msk_we = 1'b0;
    logic [N-1:0] msk_data = '0;
    logic         eoi = 1'b0;
    logic         r_flag;
    logic         ien;
    logic [11:0]  vec_save;
    logic [11:0]  vec_entry;
    logic [N-1:0] ack;
    logic [N-1:0] pend;
    logic [N-1:0] in_svc;

    int n_checks = 0;
    int n_errors = 0;

    my_interrupt_unit dut (
        .clk(clk), .reset(reset), .flag(flag), .fetch_idle(fetch_idle),
        .t2(t2), .ion(ion), .iof(iof), .msk_we(msk_we), .msk_data(msk_data),
        .eoi(eoi), .r_flag(r_flag), .ien(ien), .vec_save(vec_save),
        .vec_entry(vec_entry), .ack(ack), .pend(pend), .in_svc(in_svc)
    );

    always #5 clk = ~clk;

    // Behavioural reference state
    bit           m_r, m_ien;
    int           m_grant;
    logic [N-1:0] m_mask, m_ack, m_svc;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_r = 0; m_ien = 0; m_grant = 0;
        m_mask = '1; m_ack = '0; m_svc = '0;
    endtask

    // One clock edge: compute the model's next state from the current
    // inputs, let the edge happen, then settle before sampling.
    task automatic cyc();
        bit           n_r, n_ien, arm, ext;
        int           n_grant, ls, g;
        logic [N-1:0] elig, n_mask, n_ack, n_svc;
        if (reset) begin
            @(posedge clk); #1;
            model_reset();
            return;
        end
        elig = flag & m_mask;
`ifdef INT_NEST_EN
        ls = lowest(m_svc);
        if (ls >= 0)
            for (int k = 0; k < N; k++) if (k >= ls) elig[k] = 1'b0;
`endif
        arm = fetch_idle && m_ien && !m_r && (elig != 0);
        ext = m_r && t2;
        n_ien = m_ien;
        if (ion) n_ien = 1;
        if (iof || ext) n_ien = 0;
        n_r = m_r; n_grant = m_grant;
        if (arm) begin n_r = 1; n_grant = lowest(elig); end
        if (ext) n_r = 0;
        n_ack = ext ? N'(1 << m_grant) : '0;
        n_mask = msk_we ? msk_data : m_mask;
        n_svc = m_svc;
`ifdef INT_NEST_EN
        if (eoi) begin
            g = lowest(n_svc);
            if (g >= 0) n_svc[g] = 1'b0;
        end
        if (ext) n_svc[m_grant] = 1'b1;
`endif
        @(posedge clk); #1;
        m_r = n_r; m_ien = n_ien; m_grant = n_grant;
        m_mask = n_mask; m_ack = n_ack; m_svc = n_svc;
    endtask

    task automatic clear_inputs();
        flag = '0; fetch_idle = 0; t2 = 0; ion = 0; iof = 0;
        msk_we = 0; msk_data = '0; eoi = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1; #1;
        model_reset();
        cyc();
        reset = 0;
        cyc();
    endtask

    task automatic test_reset();
        clear_inputs();
        flag = 4'b1111;
        reset = 1; #2;
        model_reset();
        n_checks++; if (r_flag !== 1'b0) begin n_errors++; $display("FAIL reset_rflag got %b want 0", r_flag); end
        n_checks++; if (ien !== 1'b0) begin n_errors++; $display("FAIL reset_ien got %b want 0", ien); end
        n_checks++; if (ack !== 4'b0000) begin n_errors++; $display("FAIL reset_ack got %b want 0000", ack); end
        n_checks++; if (in_svc !== 4'b0000) begin n_errors++; $display("FAIL reset_insvc got %b want 0000", in_svc); end
        n_checks++; if (vec_save !== 12'h000) begin n_errors++; $display("FAIL reset_vsave got %h want 000", vec_save); end
        n_checks++; if (vec_entry !== 12'h001) begin n_errors++; $display("FAIL reset_ventry got %h want 001", vec_entry); end
        n_checks++; if (pend !== 4'b1111) begin n_errors++; $display("FAIL reset_pend got %b want 1111", pend); end
        cyc();
        reset = 0;
        flag = '0;
        cyc();
    endtask

    task automatic test_basic();
        do_reset();
        ion = 1; cyc(); ion = 0;
        n_checks++; if (ien !== 1'b1) begin n_errors++; $display("FAIL basic_ion got %b want 1", ien); end
        flag = 4'b0100; fetch_idle = 1;
        n_checks++; if (r_flag !== 1'b0) begin n_errors++; $display("FAIL basic_prearm got %b want 0", r_flag); end
        cyc(); fetch_idle = 0;
        n_checks++; if (r_flag !== 1'b1) begin n_errors++; $display("FAIL basic_arm got %b want 1", r_flag); end
        n_checks++; if (vec_save !== 12'h004) begin n_errors++; $display("FAIL basic_vsave got %h want 004", vec_save); end
        n_checks++; if (vec_entry !== 12'h005) begin n_errors++; $display("FAIL basic_ventry got %h want 005", vec_entry); end
        cyc(); cyc();
        n_checks++; if (r_flag !== 1'b1) begin n_errors++; $display("FAIL basic_hold got %b want 1", r_flag); end
        t2 = 1; cyc(); t2 = 0;
        n_checks++; if (r_flag !== 1'b0 || ien !== 1'b0) begin n_errors++; $display("FAIL basic_exit got r=%b ien=%b want 0 0", r_flag, ien); end
        n_checks++; if (ack !== 4'b0100) begin n_errors++; $display("FAIL basic_ack got %b want 0100", ack); end
        cyc();
        n_checks++; if (ack !== 4'b0000) begin n_errors++; $display("FAIL basic_ack_width got %b want 0000", ack); end
    endtask

    task automatic test_priority();
        do_reset();
        ion = 1; cyc(); ion = 0;
        flag = 4'b1010; fetch_idle = 1; cyc(); fetch_idle = 0;
        n_checks++; if (vec_save !== 12'h002) begin n_errors++; $display("FAIL prio_vsave got %h want 002", vec_save); end
        // The flag drops while armed, and the latched vector must survive.
        flag = 4'b1000; cyc();
        n_checks++; if (r_flag !== 1'b1 || vec_save !== 12'h002) begin n_errors++; $display("FAIL prio_drop got r=%b v=%h want 1 002", r_flag, vec_save); end
        flag = 4'b1010;
        t2 = 1; cyc(); t2 = 0;
        n_checks++; if (ack !== 4'b0010) begin n_errors++; $display("FAIL prio_ack got %b want 0010", ack); end
        fetch_idle = 1; cyc();
        n_checks++; if (r_flag !== 1'b0) begin n_errors++; $display("FAIL prio_noion got %b want 0", r_flag); end
        flag = 4'b1000; ion = 1; eoi = 1; cyc(); ion = 0; eoi = 0;
        cyc(); fetch_idle = 0;
        n_checks++; if (r_flag !== 1'b1 || vec_save !== 12'h006) begin n_errors++; $display("FAIL prio_src3 got r=%b v=%h want 1 006", r_flag, vec_save); end
        t2 = 1; cyc(); t2 = 0; eoi = 1; cyc(); eoi = 0;
    endtask

    task automatic test_mask();
        do_reset();
        ion = 1; msk_we = 1; msk_data = 4'b1101; cyc(); ion = 0; msk_we = 0;
        flag = 4'b0010; fetch_idle = 1;
        n_checks++; if (pend !== 4'b0000) begin n_errors++; $display("FAIL mask_pend got %b want 0000", pend); end
        cyc();
        n_checks++; if (r_flag !== 1'b0) begin n_errors++; $display("FAIL mask_noarm got %b want 0", r_flag); end
        fetch_idle = 0; msk_we = 1; msk_data = 4'b1111; cyc(); msk_we = 0;
        n_checks++; if (pend !== 4'b0010) begin n_errors++; $display("FAIL mask_pend2 got %b want 0010", pend); end
        fetch_idle = 1; cyc(); fetch_idle = 0;
        n_checks++; if (r_flag !== 1'b1 || vec_save !== 12'h002) begin n_errors++; $display("FAIL mask_arm got r=%b v=%h want 1 002", r_flag, vec_save); end
        // A mask write while armed must not cancel the cycle.
        msk_we = 1; msk_data = 4'b0000; cyc(); msk_we = 0;
        n_checks++; if (r_flag !== 1'b1) begin n_errors++; $display("FAIL mask_keep got %b want 1", r_flag); end
        t2 = 1; cyc(); t2 = 0;
        n_checks++; if (ack !== 4'b0010) begin n_errors++; $display("FAIL mask_ack got %b want 0010", ack); end
    endtask

    task automatic test_ion_iof();
        do_reset();
        ion = 1; iof = 1; cyc(); iof = 0;
        n_checks++; if (ien !== 1'b0) begin n_errors++; $display("FAIL ioniof got %b want 0", ien); end
        cyc(); ion = 0;
        flag = 4'b0001; fetch_idle = 1; cyc(); fetch_idle = 0;
        n_checks++; if (r_flag !== 1'b1 || vec_save !== 12'h000 || vec_entry !== 12'h001) begin n_errors++; $display("FAIL ion_arm0 got r=%b v=%h e=%h want 1 000 001", r_flag, vec_save, vec_entry); end
        t2 = 1; ion = 1; cyc(); t2 = 0; ion = 0;
        n_checks++; if (ien !== 1'b0) begin n_errors++; $display("FAIL ion_exit got %b want 0", ien); end
        n_checks++; if (ack !== 4'b0001) begin n_errors++; $display("FAIL ion_ack got %b want 0001", ack); end
        flag = '0; eoi = 1; cyc(); eoi = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ion = 1; cyc(); ion = 0;
        flag = 4'b0100; fetch_idle = 1; cyc(); fetch_idle = 0;
        n_checks++; if (r_flag !== 1'b1) begin n_errors++; $display("FAIL rmid_arm got %b want 1", r_flag); end
        reset = 1; #2;
        model_reset();
        n_checks++; if (r_flag !== 1'b0) begin n_errors++; $display("FAIL rmid_rflag got %b want 0", r_flag); end
        cyc(); reset = 0;
        t2 = 1; cyc(); t2 = 0;
        n_checks++; if (ack !== 4'b0000 || r_flag !== 1'b0) begin n_errors++; $display("FAIL rmid_ack got %b r=%b want 0000 0", ack, r_flag); end
        cyc();
        n_checks++; if (ack !== 4'b0000) begin n_errors++; $display("FAIL rmid_ack2 got %b want 0000", ack); end
        flag = '0;
    endtask

    task automatic test_nest();
        do_reset();
        ion = 1; cyc(); ion = 0;
        flag = 4'b0100; fetch_idle = 1; cyc(); fetch_idle = 0;
        t2 = 1; cyc(); t2 = 0;
`ifdef INT_NEST_EN
        n_checks++; if (in_svc !== 4'b0100) begin n_errors++; $display("FAIL nest_svc2 got %b want 0100", in_svc); end
        ion = 1; flag = 4'b1000; fetch_idle = 1; cyc(); ion = 0;
        cyc();
        n_checks++; if (r_flag !== 1'b0) begin n_errors++; $display("FAIL nest_block3 got %b want 0", r_flag); end
        flag = 4'b1001; cyc(); fetch_idle = 0;
        n_checks++; if (r_flag !== 1'b1 || vec_save !== 12'h000) begin n_errors++; $display("FAIL nest_pre0 got r=%b v=%h want 1 000", r_flag, vec_save); end
        t2 = 1; cyc(); t2 = 0;
        n_checks++; if (in_svc !== 4'b0101) begin n_errors++; $display("FAIL nest_svc02 got %b want 0101", in_svc); end
        eoi = 1; cyc(); eoi = 0;
        n_checks++; if (in_svc !== 4'b0100) begin n_errors++; $display("FAIL nest_eoi got %b want 0100", in_svc); end
`else
        n_checks++; if (in_svc !== 4'b0000) begin n_errors++; $display("FAIL nonest_svc got %b want 0000", in_svc); end
        ion = 1; flag = 4'b1000; fetch_idle = 1; cyc(); ion = 0;
        cyc(); fetch_idle = 0;
        n_checks++; if (r_flag !== 1'b1 || vec_save !== 12'h006) begin n_errors++; $display("FAIL nonest_arm3 got r=%b v=%h want 1 006", r_flag, vec_save); end
        t2 = 1; eoi = 1; cyc(); t2 = 0; eoi = 0;
`endif
        flag = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            flag       = N'($urandom);
            fetch_idle = ($urandom_range(0, 1) == 1);
            t2         = m_r && ($urandom_range(0, 2) == 0);
            ion        = ($urandom_range(0, 3) == 0);
            iof        = ($urandom_range(0, 15) == 0);
            msk_we     = ($urandom_range(0, 9) == 0);
            msk_data   = N'($urandom);
            eoi        = ($urandom_range(0, 7) == 0);
            cyc();
            n_checks++; if (r_flag !== m_r) begin n_errors++; $display("FAIL rnd_rflag c=%0d got %b want %b", c, r_flag, m_r); end
            n_checks++; if (ien !== m_ien) begin n_errors++; $display("FAIL rnd_ien c=%0d got %b want %b", c, ien, m_ien); end
            n_checks++; if (vec_save !== 12'(2 * m_grant)) begin n_errors++; $display("FAIL rnd_vsave c=%0d got %h want %h", c, vec_save, 12'(2 * m_grant)); end
            n_checks++; if (vec_entry !== 12'(2 * m_grant + 1)) begin n_errors++; $display("FAIL rnd_ventry c=%0d got %h want %h", c, vec_entry, 12'(2 * m_grant + 1)); end
            n_checks++; if (ack !== m_ack) begin n_errors++; $display("FAIL rnd_ack c=%0d got %b want %b", c, ack, m_ack); end
            n_checks++; if (pend !== (flag & m_mask)) begin n_errors++; $display("FAIL rnd_pend c=%0d got %b want %b", c, pend, flag & m_mask); end
            n_checks++; if (in_svc !== m_svc) begin n_errors++; $display("FAIL rnd_insvc c=%0d got %b want %b", c, in_svc, m_svc); end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_ion_iof();
        test_reset_mid();
        test_nest();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
